// File: rtl/abs_cmd_ctrl.sv
// Debug abstract-command sequencer: validates commands from dm_regs, tracks busy/cmderr,
// performs one req/gnt/rvalid register access on the core port and returns read data to data0.
module abs_cmd_ctrl #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        cmd_wr,
  input  logic [31:0] command,
  input  logic [31:0] data0,
  input  logic        cmderr_clr,
  input  logic        hart_halted,
  output logic        busy,
  output logic [2:0]  cmderr,
  output logic        acc_req,
  output logic        acc_wr,
  output logic [15:0] acc_regno,
  output logic [31:0] acc_wdata,
  input  logic        acc_gnt,
  input  logic        acc_rvalid,
  input  logic [31:0] acc_rdata,
  input  logic        acc_err,
  output logic        data0_we,
  output logic [31:0] data0_wdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_e;

  state_e             state_q, state_d;
  logic [2:0]         cmderr_q, cmderr_d;
  logic               acc_wr_q, acc_wr_d;
  logic [15:0]        acc_regno_q, acc_regno_d;
  logic [31:0]        acc_wdata_q, acc_wdata_d;
  logic               data0_we_q, data0_we_d;
  logic [31:0]        data0_wdata_q, data0_wdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [7:0]  cmd_type;
  logic [2:0]  cmd_aarsize;
  logic        cmd_postexec;
  logic        cmd_transfer;
  logic        cmd_write;
  logic [15:0] cmd_regno;
  logic        regno_ok;
  logic        cnt_last;

  assign cmd_type     = command[31:24];
  assign cmd_aarsize  = command[22:20];
  assign cmd_postexec = command[18];
  assign cmd_transfer = command[17];
  assign cmd_write    = command[16];
  assign cmd_regno    = command[15:0];
  // CSRs occupy 0x0000-0x0FFF and GPRs 0x1000-0x101F, so one upper bound covers both.
  assign regno_ok     = (cmd_regno <= 16'h101F);
  assign cnt_last     = (cnt_q >= CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d       = state_q;
    cmderr_d      = cmderr_q;
    acc_wr_d      = acc_wr_q;
    acc_regno_d   = acc_regno_q;
    acc_wdata_d   = acc_wdata_q;
    data0_we_d    = 1'b0;
    data0_wdata_d = data0_wdata_q;
    cnt_d         = cnt_q;

    // Clear is applied first so any error raised in the same cycle overrides it.
    if (cmderr_clr) cmderr_d = 3'd0;

    case (state_q)
      IDLE: begin
        if (cmd_wr) begin
          if (cmderr_q != 3'd0) begin
            cmderr_d = cmderr_q;
          end else if ((cmd_type != 8'd0) || cmd_postexec) begin
            cmderr_d = 3'd2;
          end else if (!cmd_transfer) begin
            cmderr_d = cmderr_q;
          end else if (cmd_aarsize != 3'd2) begin
            cmderr_d = 3'd2;
          end else if (!hart_halted) begin
            cmderr_d = 3'd4;
          end else if (!regno_ok) begin
            cmderr_d = 3'd3;
          end else begin
            acc_wr_d    = cmd_write;
            acc_regno_d = cmd_regno;
            acc_wdata_d = data0;
            cnt_d       = '0;
            state_d     = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (cmd_wr && (cmderr_q == 3'd0)) cmderr_d = 3'd1;
        if (acc_gnt && acc_wr_q) begin
          state_d = IDLE;
          if (acc_err) cmderr_d = 3'd3;
        end else if (cnt_last) begin
          cmderr_d = 3'd7;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (acc_gnt) state_d = WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (cmd_wr && (cmderr_q == 3'd0)) cmderr_d = 3'd1;
        if (acc_rvalid) begin
          state_d = IDLE;
          if (acc_err) begin
            cmderr_d = 3'd3;
          end else begin
            data0_we_d    = 1'b1;
            data0_wdata_d = acc_rdata;
          end
        end else if (cnt_last) begin
          cmderr_d = 3'd7;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q       <= IDLE;
      cmderr_q      <= 3'd0;
      acc_wr_q      <= 1'b0;
      acc_regno_q   <= 16'd0;
      acc_wdata_q   <= 32'd0;
      data0_we_q    <= 1'b0;
      data0_wdata_q <= 32'd0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      cmderr_q      <= cmderr_d;
      acc_wr_q      <= acc_wr_d;
      acc_regno_q   <= acc_regno_d;
      acc_wdata_q   <= acc_wdata_d;
      data0_we_q    <= data0_we_d;
      data0_wdata_q <= data0_wdata_d;
      cnt_q         <= cnt_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign acc_req     = (state_q == ISSUE);
  assign cmderr      = cmderr_q;
  assign acc_wr      = acc_wr_q;
  assign acc_regno   = acc_regno_q;
  assign acc_wdata   = acc_wdata_q;
  assign data0_we    = data0_we_q;
  assign data0_wdata = data0_wdata_q;

endmodule
